// File: rtl/wbs_ctrl_if.sv
// Wishbone classic slave-side bus bundle between the management SoC and the ANN bridge.
interface wbs_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wbs_ctrl.sv
// Wishbone slave bridge: control registers, query/leaf/best SRAM ports and node registers,
// with 55/64-bit memory words split into 32-bit lower/upper halves.
module wbs_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int ROW_SIZE   = 24,
    parameter int COL_SIZE   = 17,
    parameter int K          = 4,
    parameter int NUM_LEAVES = 64,
    localparam int PW      = DATA_WIDTH * PATCH_SIZE,
    localparam int QP_AW   = $clog2(ROW_SIZE * COL_SIZE),
    localparam int LEAF_AW = $clog2(NUM_LEAVES),
    localparam int BANK_W  = $clog2(LEAF_SIZE)
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_n,
    wbs_ctrl_if.slave             wb,
    output logic                  wbs_mode,
    output logic                  wbs_debug,
    output logic                  wbs_qp_mem_csb0,
    output logic                  wbs_qp_mem_web0,
    output logic [QP_AW-1:0]      wbs_qp_mem_addr0,
    output logic [PW-1:0]         wbs_qp_mem_wpatch0,
    input  logic [PW-1:0]         wbs_qp_mem_rpatch0,
    output logic [LEAF_SIZE-1:0]  wbs_leaf_mem_csb0,
    output logic [LEAF_SIZE-1:0]  wbs_leaf_mem_web0,
    output logic [LEAF_AW-1:0]    wbs_leaf_mem_addr0,
    output logic [63:0]           wbs_leaf_mem_wleaf0,
    input  logic [63:0]           wbs_leaf_mem_rleaf0 [LEAF_SIZE],
    output logic                  wbs_node_mem_web,
    output logic [31:0]           wbs_node_mem_addr,
    output logic [31:0]           wbs_node_mem_wdata,
    input  logic [31:0]           wbs_node_mem_rdata,
    output logic                  wbs_best_arr_csb1,
    output logic [7:0]            wbs_best_arr_addr1,
    input  logic [63:0]           wbs_best_arr_rdata1
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    localparam logic [15:0] RG_REG  = 16'h3000;
    localparam logic [15:0] RG_QP   = 16'h3001;
    localparam logic [15:0] RG_LEAF = 16'h3002;
    localparam logic [15:0] RG_BEST = 16'h3003;
    localparam logic [15:0] RG_NODE = 16'h3004;

    logic [1:0]           state;
    logic [31:0]          adr_q;
    logic                 we_q;
    logic [31:0]          lo_buf;
    logic [LEAF_SIZE-1:0] bank_oh;
    logic [63:0]          rleaf_sel;
    logic                 req;
    logic                 unused_bits;

    assign req         = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign bank_oh     = {{(LEAF_SIZE-1){1'b0}}, 1'b1} << wb.wbs_adr_i[3 +: BANK_W];
    assign rleaf_sel   = wbs_leaf_mem_rleaf0[adr_q[3 +: BANK_W]];
    assign unused_bits = ^{wb.wbs_sel_i, (K > 0)};

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            adr_q              <= '0;
            we_q               <= 1'b0;
            lo_buf             <= '0;
            wbs_mode           <= 1'b0;
            wbs_debug          <= 1'b0;
            wb.wbs_ack_o       <= 1'b0;
            wb.wbs_dat_o       <= '0;
            wbs_qp_mem_csb0    <= 1'b1;
            wbs_qp_mem_web0    <= 1'b1;
            wbs_qp_mem_addr0   <= '0;
            wbs_qp_mem_wpatch0 <= '0;
            wbs_leaf_mem_csb0  <= '1;
            wbs_leaf_mem_web0  <= '1;
            wbs_leaf_mem_addr0 <= '0;
            wbs_leaf_mem_wleaf0<= '0;
            wbs_node_mem_web   <= 1'b0;
            wbs_node_mem_addr  <= '0;
            wbs_node_mem_wdata <= '0;
            wbs_best_arr_csb1  <= 1'b1;
            wbs_best_arr_addr1 <= '0;
        end else begin
            // Strobes only live for the single MEM cycle; everything else re-idles here.
            wb.wbs_ack_o      <= 1'b0;
            wbs_qp_mem_csb0   <= 1'b1;
            wbs_qp_mem_web0   <= 1'b1;
            wbs_leaf_mem_csb0 <= '1;
            wbs_leaf_mem_web0 <= '1;
            wbs_node_mem_web  <= 1'b0;
            wbs_best_arr_csb1 <= 1'b1;
            case (state)
                IDLE: if (req) begin
                    adr_q <= wb.wbs_adr_i;
                    we_q  <= wb.wbs_we_i;
                    state <= ACK;
                    wb.wbs_ack_o <= 1'b1;
                    case (wb.wbs_adr_i[31:16])
                        RG_REG: begin
                            if (wb.wbs_we_i) begin
                                if (wb.wbs_adr_i[15:0] == 16'h0000) wbs_mode  <= wb.wbs_dat_i[0];
                                if (wb.wbs_adr_i[15:0] == 16'h0004) wbs_debug <= wb.wbs_dat_i[0];
                            end else begin
                                case (wb.wbs_adr_i[15:0])
                                    16'h0000: wb.wbs_dat_o <= {31'b0, wbs_mode};
                                    16'h0004: wb.wbs_dat_o <= {31'b0, wbs_debug};
                                    default:  wb.wbs_dat_o <= '0;
                                endcase
                            end
                        end
                        RG_QP: begin
                            if (wb.wbs_we_i && !wb.wbs_adr_i[2]) begin
                                lo_buf <= wb.wbs_dat_i;
                            end else begin
                                state            <= MEM;
                                wb.wbs_ack_o     <= 1'b0;
                                wbs_qp_mem_csb0  <= 1'b0;
                                wbs_qp_mem_web0  <= ~wb.wbs_we_i;
                                wbs_qp_mem_addr0 <= wb.wbs_adr_i[3 +: QP_AW];
                                if (wb.wbs_we_i) wbs_qp_mem_wpatch0 <= {wb.wbs_dat_i[PW-33:0], lo_buf};
                            end
                        end
                        RG_LEAF: begin
                            if (wb.wbs_we_i && !wb.wbs_adr_i[2]) begin
                                lo_buf <= wb.wbs_dat_i;
                            end else begin
                                state              <= MEM;
                                wb.wbs_ack_o       <= 1'b0;
                                wbs_leaf_mem_csb0  <= ~bank_oh;
                                wbs_leaf_mem_web0  <= wb.wbs_we_i ? ~bank_oh : '1;
                                wbs_leaf_mem_addr0 <= wb.wbs_adr_i[3+BANK_W +: LEAF_AW];
                                if (wb.wbs_we_i) wbs_leaf_mem_wleaf0 <= {wb.wbs_dat_i, lo_buf};
                            end
                        end
                        RG_BEST: begin
                            if (!wb.wbs_we_i) begin
                                state              <= MEM;
                                wb.wbs_ack_o       <= 1'b0;
                                wbs_best_arr_csb1  <= 1'b0;
                                wbs_best_arr_addr1 <= wb.wbs_adr_i[10:3];
                            end
                        end
                        RG_NODE: begin
                            state             <= MEM;
                            wb.wbs_ack_o      <= 1'b0;
                            wbs_node_mem_addr <= {24'b0, wb.wbs_adr_i[7:0]};
                            if (wb.wbs_we_i) begin
                                wbs_node_mem_web   <= 1'b1;
                                wbs_node_mem_wdata <= wb.wbs_dat_i;
                            end
                        end
                        default: if (!wb.wbs_we_i) wb.wbs_dat_o <= '0;
                    endcase
                end
                MEM: begin
                    state <= we_q ? ACK : WAIT;
                    wb.wbs_ack_o <= we_q;
                end
                WAIT: begin
                    state        <= ACK;
                    wb.wbs_ack_o <= 1'b1;
                    case (adr_q[31:16])
                        RG_QP:   wb.wbs_dat_o <= adr_q[2] ? 32'(wbs_qp_mem_rpatch0[PW-1:32])
                                                          : wbs_qp_mem_rpatch0[31:0];
                        RG_LEAF: wb.wbs_dat_o <= adr_q[2] ? rleaf_sel[63:32] : rleaf_sel[31:0];
                        RG_BEST: wb.wbs_dat_o <= adr_q[2] ? wbs_best_arr_rdata1[63:32]
                                                          : wbs_best_arr_rdata1[31:0];
                        RG_NODE: wb.wbs_dat_o <= wbs_node_mem_rdata;
                        default: wb.wbs_dat_o <= '0;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbs_ctrl.sv
// Directed bench for wbs_ctrl: registers, query/leaf/best/node paths, latency and strobe shape.
module tb_wbs_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mode, debug;
    logic        qp_csb, qp_web;
    logic [8:0]  qp_addr;
    logic [54:0] qp_wpatch, qp_rpatch;
    logic [7:0]  leaf_csb, leaf_web;
    logic [5:0]  leaf_addr;
    logic [63:0] leaf_wleaf;
    logic [63:0] rleaf [8];
    logic        node_web;
    logic [31:0] node_addr, node_wdata, node_rdata;
    logic        best_csb;
    logic [7:0]  best_addr;
    logic [63:0] best_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-transaction observations filled in by xfer
    int          lat;
    logic [31:0] rd;
    logic        ack_after;
    int          m_qp_n, m_node_n, m_best_n;
    logic        m_qp_web;
    logic [8:0]  m_qp_addr;
    logic [54:0] m_wpatch;
    logic [7:0]  m_leaf_cs, m_leaf_we;
    logic [5:0]  m_leaf_addr;
    logic [63:0] m_wleaf;
    logic [31:0] m_node_addr, m_node_wdata;
    logic [7:0]  m_best_addr;

    wbs_ctrl_if wb ();

    wbs_ctrl dut (
        .wb_clk_i(clk), .rst_n(rst_n), .wb(wb.slave),
        .wbs_mode(mode), .wbs_debug(debug),
        .wbs_qp_mem_csb0(qp_csb), .wbs_qp_mem_web0(qp_web), .wbs_qp_mem_addr0(qp_addr),
        .wbs_qp_mem_wpatch0(qp_wpatch), .wbs_qp_mem_rpatch0(qp_rpatch),
        .wbs_leaf_mem_csb0(leaf_csb), .wbs_leaf_mem_web0(leaf_web), .wbs_leaf_mem_addr0(leaf_addr),
        .wbs_leaf_mem_wleaf0(leaf_wleaf), .wbs_leaf_mem_rleaf0(rleaf),
        .wbs_node_mem_web(node_web), .wbs_node_mem_addr(node_addr),
        .wbs_node_mem_wdata(node_wdata), .wbs_node_mem_rdata(node_rdata),
        .wbs_best_arr_csb1(best_csb), .wbs_best_arr_addr1(best_addr),
        .wbs_best_arr_rdata1(best_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        lat = 0; rd = 'x;
        m_qp_n = 0; m_node_n = 0; m_best_n = 0;
        m_leaf_cs = '0; m_leaf_we = '0;
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = 4'hF;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (!qp_csb) begin
                m_qp_n++; m_qp_web = qp_web; m_qp_addr = qp_addr; m_wpatch = qp_wpatch;
            end
            if (leaf_csb != 8'hFF) begin
                m_leaf_addr = leaf_addr; m_wleaf = leaf_wleaf;
            end
            m_leaf_cs = m_leaf_cs | ~leaf_csb;
            m_leaf_we = m_leaf_we | ~leaf_web;
            if (node_web) begin
                m_node_n++; m_node_addr = node_addr; m_node_wdata = node_wdata;
            end
            if (!best_csb) begin
                m_best_n++; m_best_addr = best_addr;
            end
            if (wb.wbs_ack_o) begin
                lat = c; rd = wb.wbs_dat_o;
                break;
            end
        end
        @(negedge clk);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        @(posedge clk); #1;
        ack_after = wb.wbs_ack_o;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({mode, debug, wb.wbs_ack_o, node_web} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_flags got %b exp 0000", {mode, debug, wb.wbs_ack_o, node_web});
        end
        n_tests++;
        if (wb.wbs_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_dat_o got %h exp 00000000", wb.wbs_dat_o);
        end
        n_tests++;
        if ({qp_csb, qp_web, leaf_csb, leaf_web, best_csb} !== {2'b11, 8'hFF, 8'hFF, 1'b1}) begin
            n_fail++; $display("FAIL rst_strobes got %b exp all ones", {qp_csb, qp_web, leaf_csb, leaf_web, best_csb});
        end
        n_tests++;
        if ({qp_addr, leaf_addr, best_addr, node_addr, qp_wpatch, leaf_wleaf, node_wdata} !== '0) begin
            n_fail++; $display("FAIL rst_addr_data got nonzero exp 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_regs;
        xfer(1'b1, 32'h3000_0004, 32'h1);
        n_tests++;
        if (debug !== 1'b1 || lat !== 1 || ack_after !== 1'b0) begin
            n_fail++; $display("FAIL reg_debug1 got dbg=%b lat=%0d ack2=%b exp 1 1 0", debug, lat, ack_after);
        end
        xfer(1'b1, 32'h3000_0000, 32'h1);
        n_tests++;
        if (mode !== 1'b1 || lat !== 1 || ack_after !== 1'b0) begin
            n_fail++; $display("FAIL reg_mode1 got mode=%b lat=%0d ack2=%b exp 1 1 0", mode, lat, ack_after);
        end
        xfer(1'b1, 32'h3000_0004, 32'hFFFF_FFFE);
        n_tests++;
        if (debug !== 1'b0 || mode !== 1'b1) begin
            n_fail++; $display("FAIL reg_debug0 got dbg=%b mode=%b exp 0 1", debug, mode);
        end
        xfer(1'b0, 32'h3000_0000, 32'h0);
        n_tests++;
        if (rd !== 32'h1 || lat !== 1) begin
            n_fail++; $display("FAIL reg_rd_mode got %h lat=%0d exp 00000001 1", rd, lat);
        end
        xfer(1'b1, 32'h3000_0008, 32'h1);
        xfer(1'b0, 32'h3000_0008, 32'h0);
        n_tests++;
        if (rd !== 32'h0 || mode !== 1'b1 || debug !== 1'b0) begin
            n_fail++; $display("FAIL reg_done got %h m=%b d=%b exp 0 1 0", rd, mode, debug);
        end
    endtask

    task automatic test_query;
        qp_rpatch = 55'h00_1010_DEAD_BEEF;
        xfer(1'b0, 32'h3001_0008, 32'h0);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF || lat !== 3) begin
            n_fail++; $display("FAIL qp_rd_lo got %h lat=%0d exp deadbeef 3", rd, lat);
        end
        n_tests++;
        if (m_qp_n !== 1 || m_qp_web !== 1'b1 || m_qp_addr !== 9'd1 || m_leaf_cs !== 8'h00) begin
            n_fail++; $display("FAIL qp_rd_strobe got n=%0d web=%b addr=%0d leaf=%h exp 1 1 1 00",
                               m_qp_n, m_qp_web, m_qp_addr, m_leaf_cs);
        end
        xfer(1'b0, 32'h3001_000C, 32'h0);
        n_tests++;
        if (rd !== 32'h0000_1010) begin
            n_fail++; $display("FAIL qp_rd_hi got %h exp 00001010", rd);
        end
        xfer(1'b1, 32'h3001_0010, 32'h0123_4567);
        n_tests++;
        if (m_qp_n !== 0 || lat !== 1 || wb.wbs_dat_o !== 32'h0000_1010) begin
            n_fail++; $display("FAIL qp_wr_lo got n=%0d lat=%0d dat_o=%h exp 0 1 00001010",
                               m_qp_n, lat, wb.wbs_dat_o);
        end
        xfer(1'b1, 32'h3001_0014, 32'h000B_CDEF);
        n_tests++;
        if (m_qp_n !== 1 || m_qp_web !== 1'b0 || m_qp_addr !== 9'd2 || lat !== 2) begin
            n_fail++; $display("FAIL qp_wr_hi got n=%0d web=%b addr=%0d lat=%0d exp 1 0 2 2",
                               m_qp_n, m_qp_web, m_qp_addr, lat);
        end
        n_tests++;
        if (m_wpatch !== 55'h0B_CDEF_0123_4567) begin
            n_fail++; $display("FAIL qp_wpatch got %h exp 0bcdef01234567", m_wpatch);
        end
    endtask

    task automatic test_leaf;
        for (int i = 0; i < 8; i++) rleaf[i] = {32'h5500_0000 + i, 32'hAA00_0000 + i};
        rleaf[7] = 64'h1100_1010_DEAD_BEEF;
        xfer(1'b0, 32'h3002_0038, 32'h0);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF || m_leaf_cs !== 8'h80 || m_leaf_we !== 8'h00 || lat !== 3) begin
            n_fail++; $display("FAIL leaf_rd_lo got %h cs=%h we=%h lat=%0d exp deadbeef 80 00 3",
                               rd, m_leaf_cs, m_leaf_we, lat);
        end
        xfer(1'b0, 32'h3002_003C, 32'h0);
        n_tests++;
        if (rd !== 32'h1100_1010 || m_leaf_cs !== 8'h80) begin
            n_fail++; $display("FAIL leaf_rd_hi got %h cs=%h exp 11001010 80", rd, m_leaf_cs);
        end
        xfer(1'b0, 32'h3002_0054, 32'h0);
        n_tests++;
        if (rd !== 32'h5500_0002 || m_leaf_cs !== 8'h04 || m_leaf_addr !== 6'd1) begin
            n_fail++; $display("FAIL leaf_rd_b2 got %h cs=%h addr=%0d exp 55000002 04 1",
                               rd, m_leaf_cs, m_leaf_addr);
        end
        xfer(1'b1, 32'h3002_0018, 32'h7654_3210);
        n_tests++;
        if (m_leaf_cs !== 8'h00 || lat !== 1) begin
            n_fail++; $display("FAIL leaf_wr_lo got cs=%h lat=%0d exp 00 1", m_leaf_cs, lat);
        end
        xfer(1'b1, 32'h3002_001C, 32'hFEDC_BA98);
        n_tests++;
        if (m_leaf_cs !== 8'h08 || m_leaf_we !== 8'h08 || m_leaf_addr !== 6'd0 ||
            m_wleaf !== 64'hFEDC_BA98_7654_3210 || lat !== 2) begin
            n_fail++; $display("FAIL leaf_wr_hi got cs=%h we=%h addr=%0d data=%h lat=%0d exp 08 08 0 fedcba9876543210 2",
                               m_leaf_cs, m_leaf_we, m_leaf_addr, m_wleaf, lat);
        end
    endtask

    task automatic test_best;
        best_rdata = 64'h1100_1010_DEAD_BEEF;
        xfer(1'b0, 32'h3003_0038, 32'h0);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF || m_best_n !== 1 || m_best_addr !== 8'd7 || lat !== 3) begin
            n_fail++; $display("FAIL best_rd_lo got %h n=%0d addr=%0d lat=%0d exp deadbeef 1 7 3",
                               rd, m_best_n, m_best_addr, lat);
        end
        xfer(1'b0, 32'h3003_003C, 32'h0);
        n_tests++;
        if (rd !== 32'h1100_1010 || m_best_addr !== 8'd7) begin
            n_fail++; $display("FAIL best_rd_hi got %h addr=%0d exp 11001010 7", rd, m_best_addr);
        end
        xfer(1'b1, 32'h3003_0038, 32'h1234_5678);
        n_tests++;
        if (m_best_n !== 0 || lat !== 1) begin
            n_fail++; $display("FAIL best_wr got n=%0d lat=%0d exp 0 1", m_best_n, lat);
        end
    endtask

    task automatic test_node;
        xfer(1'b1, 32'h3004_0001, {10'b0, 11'd55, 11'd1});
        n_tests++;
        if (m_node_n !== 1 || m_node_addr !== 32'd1 || m_node_wdata !== 32'h0001_B801 || lat !== 2) begin
            n_fail++; $display("FAIL node_wr1 got n=%0d addr=%h data=%h lat=%0d exp 1 1 0001b801 2",
                               m_node_n, m_node_addr, m_node_wdata, lat);
        end
        node_rdata = 32'h0001_B801;
        xfer(1'b0, 32'h3004_0001, 32'h0);
        n_tests++;
        if (rd !== 32'h0001_B801 || m_node_n !== 0 || node_addr !== 32'd1 || lat !== 3) begin
            n_fail++; $display("FAIL node_rd1 got %h n=%0d addr=%h lat=%0d exp 0001b801 0 1 3",
                               rd, m_node_n, node_addr, lat);
        end
        xfer(1'b1, 32'h3004_003F, {10'b0, 11'd42, 11'd2});
        n_tests++;
        if (m_node_n !== 1 || m_node_addr !== 32'd63 || m_node_wdata !== 32'h0001_5002) begin
            n_fail++; $display("FAIL node_wr63 got n=%0d addr=%h data=%h exp 1 3f 00015002",
                               m_node_n, m_node_addr, m_node_wdata);
        end
        node_rdata = 32'h0001_5002;
        xfer(1'b0, 32'h3004_003F, 32'h0);
        n_tests++;
        if (rd !== 32'h0001_5002 || node_addr !== 32'd63) begin
            n_fail++; $display("FAIL node_rd63 got %h addr=%h exp 00015002 3f", rd, node_addr);
        end
    endtask

    task automatic test_unmapped;
        xfer(1'b0, 32'h3005_0000, 32'h0);
        n_tests++;
        if (rd !== 32'h0 || lat !== 1) begin
            n_fail++; $display("FAIL unmapped_rd got %h lat=%0d exp 0 1", rd, lat);
        end
        xfer(1'b1, 32'h4000_0000, 32'hFFFF_FFFF);
        n_tests++;
        if (lat !== 1 || m_qp_n !== 0 || m_node_n !== 0 || m_leaf_cs !== 8'h00 || mode !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_wr got lat=%0d qp=%0d node=%0d leaf=%h mode=%b exp 1 0 0 00 1",
                               lat, m_qp_n, m_node_n, m_leaf_cs, mode);
        end
    endtask

    task automatic test_back_to_back;
        int acks;
        logic prev;
        logic dbl;
        acks = 0; prev = 1'b0; dbl = 1'b0;
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = 32'h3000_0000;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) acks++;
            if (wb.wbs_ack_o && prev) dbl = 1'b1;
            prev = wb.wbs_ack_o;
        end
        @(negedge clk);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        n_tests++;
        if (acks !== 3 || dbl !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back got acks=%0d dbl=%b exp 3 0", acks, dbl);
        end
    endtask

    task automatic test_reset_mid;
        logic saw_ack;
        saw_ack = 1'b0;
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = 32'h3001_0008;
        @(posedge clk); #1;
        n_tests++;
        if (qp_csb !== 1'b0) begin
            n_fail++; $display("FAIL mid_pre got csb=%b exp 0", qp_csb);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (qp_csb !== 1'b1 || mode !== 1'b0) begin
            n_fail++; $display("FAIL mid_async got csb=%b mode=%b exp 1 0", qp_csb, mode);
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) saw_ack = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h3000_0004, 32'h0);
        n_tests++;
        if (saw_ack !== 1'b0 || lat !== 1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL mid_recover got ack=%b lat=%0d rd=%h exp 0 1 0", saw_ack, lat, rd);
        end
    endtask

    initial begin
        qp_rpatch = '0; best_rdata = '0; node_rdata = '0;
        for (int i = 0; i < 8; i++) rleaf[i] = '0;
        test_reset();
        test_regs();
        test_query();
        test_leaf();
        test_best();
        test_node();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wbs_ctrl.md
Name: wbs_ctrl

Overview:
- Wishbone slave bridge between the management SoC and the ANN accelerator's debug and storage resources.
- Decodes 32-bit Wishbone classic transactions into three things:
  - control registers (mode, debug);
  - single-port SRAM accesses: query-patch memory, 8 leaf-memory banks, best-match array;
  - internal-node tree register accesses.
- Splits wide (55/64-bit) memory words into 32-bit lower/upper halves.

Parameters:
DATA_WIDTH 11 bits per patch element
LEAF_SIZE 8 number of leaf-memory banks
PATCH_SIZE 5 elements per patch (patch word = 55 bits)
ROW_SIZE 24 query rows
COL_SIZE 17 query columns (NUM_QUERYS = 408, qp addr width = clog2(408) = 9)
K 4 neighbours per query (unused by bridge logic)
NUM_LEAVES 64 leaf entries per bank (LEAF_ADDRW = 6)

Ports:
wb_clk_i in 1 clock
rst_n in 1 asynchronous active-low reset
wbs_stb_i, wbs_cyc_i, wbs_we_i in 1 Wishbone strobe/cycle/write
wbs_sel_i in 4 byte select (ignored; full-word access)
wbs_dat_i in 32 write data
wbs_adr_i in 32 byte address
wbs_ack_o out 1 acknowledge
wbs_dat_o out 32 read data
wbs_mode out 1 mode register
wbs_debug out 1 debug register
wbs_qp_mem_csb0, wbs_qp_mem_web0 out 1 query mem chip-select / write-enable, active-low
wbs_qp_mem_addr0 out 9 query mem address
wbs_qp_mem_wpatch0 out 55 (5x11 packed) write patch
wbs_qp_mem_rpatch0 in 55 read patch
wbs_leaf_mem_csb0, wbs_leaf_mem_web0 out 8 per-bank active-low csb/web
wbs_leaf_mem_addr0 out 6 leaf address
wbs_leaf_mem_wleaf0 out 64 leaf write data
wbs_leaf_mem_rleaf0 in 8x64 (unpacked) per-bank read data
wbs_node_mem_web out 1 node write enable, ACTIVE-HIGH
wbs_node_mem_addr out 32 node address
wbs_node_mem_wdata out 32 node write data
wbs_node_mem_rdata in 32 node read data
wbs_best_arr_csb1 out 1 best-array read select, active-low
wbs_best_arr_addr1 out 8 best-array address
wbs_best_arr_rdata1 in 64 best-array read data

Behaviour:
- Reset (async, rst_n=0):
  - mode, debug, ack, dat_o, node_mem_web = 0.
  - All csb/web = 1.
  - Addresses, write data and lower-half buffer = 0.
  - FSM returns to IDLE.
- Region decode uses adr & 32'hFFFF_0000:
  - 3000_0000 regs: offset 0 mode, 4 debug, 8 done. Done is reserved: reads 0, writes ignored.
  - 3001 query, 3002 leaf, 3003 best, 3004 node.
  - Unmapped addresses: ack'd, reads 0.
- Half select: adr[2] (0 = lower bits [31:0], 1 = upper bits, zero-extended on read).
- Address fields:
  - query entry = adr[11:3].
  - leaf: bank = adr[5:3], entry = adr[11:6].
  - best entry = adr[10:3].
  - node: addr = {24'b0, adr[7:0]}, word-indexed, no shift.
- FSM states: IDLE, MEM, WAIT, ACK.
- Start: IDLE samples cyc&stb at posedge.
- Register write/read: IDLE->ACK. Writes load dat_i[0] into the register; reads return {31'b0, reg}.
- Lower-half write (query/leaf): latch dat_i into a 32-bit buffer, no memory access; IDLE->ACK.
- Upper-half write (query/leaf):
  - IDLE->MEM: for one cycle, csb=0 and web=0 on the selected memory/bank.
  - Write data: qp wpatch = {dat_i[22:0], buffer}; leaf wleaf = {dat_i, buffer}.
  - Then MEM->ACK.
- Best-array writes: ack'd, ignored.
- Memory read:
  - MEM: csb=0, web=1 (best: csb1=0) for exactly one cycle.
  - WAIT: capture rdata (selected bank for leaf) at end of WAIT.
  - ACK: dat_o = selected half.
- Node write: MEM asserts node_mem_web=1 with addr and wdata=dat_i for one cycle, then ACK.
- Node read: MEM drives addr; WAIT captures node_mem_rdata; ACK.
- Read latency: 3 cycles after request sample. Write latency: 1 cycle (reg/lower) or 2 cycles (memory/node).
- ack: single-cycle pulse; FSM returns to IDLE.
- dat_o: holds last read value until the next read.
- If stb/cyc remain high after ack, a new transaction starts at the next IDLE sample.
- Strobes are deasserted outside MEM; web idles 1.
- Reset mid-transaction aborts the transaction with no ack.

Test Plan:
1. Write DEBUG=1, MODE=1, then DEBUG=0 -> wbs_debug 1 then 0; wbs_mode=1; each write gets a single ack pulse.
2. Query read, adr 3001_0008 (lower), rpatch=55'h00_1010_DEAD_BEEF -> addr0=1, csb0=0/web0=1 for one cycle; dat_o=DEAD_BEEF. Same at 3001_000C -> dat_o=0000_1010.
3. Query write, 3001_0010 with 01234567 then 3001_0014 with 000BCDEF -> no strobe on the first write; on the second: addr0=2, web0=0, wpatch0=55'h0BCDEF_01234567.
4. Leaf read, 3002_0038 / 3002_003C, rleaf0[7]=64'h1100_1010_DEAD_BEEF -> only bank 7 strobed; dat_o DEAD_BEEF then 1100_1010. Leaf write 3002_0018/1C (76543210, FEDCBA98) -> bank 3 written with 64'hFEDCBA98_76543210.
5. Best read, 3003_0038 lower/upper -> addr1=7; dat_o DEAD_BEEF then 1100_1010.
6. Node: write 3004_0001 with {10'b0,11'd55,11'd1} -> node_mem_web=1, addr=1 for one cycle. Read 3004_0001 -> dat_o = node_mem_rdata. Repeat at addr 63 with {10'b0,11'd42,11'd2}.
